stream_packetizer: RTL and testbench
====================================

STREAM_PACKETIZER -- requirements
Module: stream_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Stream tdata width in bits (multiple of 8, 8..512).
REQ-002 SHALL have parameter LEN_WIDTH, default 32, width of the packet-length and counter registers (2..32).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width; only bits [4:2] are decoded.
REQ-004 aclk  in  1  single clock; all logic is on its rising edge.
REQ-005 areset  in  1  reset, synchronous and active-high.
REQ-006 s_axis_data_tdata/tvalid/tready  in/in/out  DATA_WIDTH/1/1  upstream sample stream.
REQ-007 m_axis_s2mm_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  downstream DMA stream.
REQ-008 last  out  1  one-cycle pulse on each accepted final beat of a packet.
REQ-009 irq  out  1  level, set when a one-shot run completes, cleared by a write to STATUS.
REQ-010 s_axi_lite_* full AXI4-Lite subordinate, 32-bit data, awprot/arprot ignored.

Function
REQ-011 Registers (byte offset): 0x00 CTRL rw (bit0 enable, bit1 continuous), 0x04 LENGTH rw (beats/packet), 0x08 NPACKETS rw (one-shot packet count), 0x0C STATUS (bit0 busy, bit1 done; write any value clears done and irq), 0x10 BEATS ro (beat index in current packet), 0x14 PACKETS ro (packets completed since start).
REQ-012 Writes honour wstrb per byte; register bits above LEN_WIDTH read 0; writes to ro offsets or unmapped offsets -> bresp SLVERR, no effect; reads of unmapped offsets -> rdata 0, rresp SLVERR.
REQ-013 AXI4-Lite write: awready and wready asserted together only when awvalid and wvalid are both high and no bvalid is pending; bvalid asserted the next cycle and held until bready.
REQ-014 AXI4-Lite read: arready high when rvalid low; rdata/rresp registered, rvalid the cycle after handshake, held until rready.
REQ-015 FSM states IDLE, ARM, RUN, DRAIN.
REQ-016 IDLE: s_axis_data_tready=0, m_axis_s2mm_tvalid=0; enable rising 0->1 with LENGTH!=0 -> ARM; enable set with LENGTH=0 stays IDLE.
REQ-017 ARM (one cycle): latch LENGTH into active_len, NPACKETS into active_npk, clear BEATS and PACKETS, clear done; -> RUN.
REQ-018 RUN/DRAIN: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready (combinational pass-through, zero latency).
REQ-019 A beat is counted only on s_tvalid & s_tready; BEATS increments per beat, modulo active_len.
REQ-020 tlast=1 combinationally while in RUN/DRAIN and BEATS==active_len-1; last pulses on that beat's handshake.
REQ-021 On final-beat handshake: BEATS->0, PACKETS+1 (wraps at 2^LEN_WIDTH), LENGTH re-latched into active_len so LENGTH writes take effect only at packet boundaries.
REQ-022 One-shot (continuous=0): final beat of packet number active_npk -> IDLE, done=1, irq=1; active_npk=0 means unlimited.
REQ-023 Continuous (continuous=1): packets repeat indefinitely.
REQ-024 enable cleared during RUN -> DRAIN; DRAIN completes the current packet then -> IDLE without setting done; if BEATS==0 with no beat in flight -> IDLE immediately.
REQ-025 LENGTH=0 re-latched at a boundary -> IDLE, done unchanged.
REQ-026 Simultaneous enable clear and final-beat handshake -> IDLE, packet counted, tlast asserted on that beat.
REQ-027 active_len=1: every beat carries tlast.
REQ-028 busy = state != IDLE.

Reset
REQ-029 areset high on a clock edge -> state IDLE, all registers 0, BEATS=PACKETS=0, tvalid/tready/tlast/last/irq=0, awready/wready/arready/bvalid/rvalid=0; an in-flight packet is abandoned with no tlast.
REQ-030 Outputs reach reset values one cycle after areset sampled high and remain there while areset is high.

Verification
REQ-031 LENGTH=4, NPACKETS=2, CTRL=1, continuous stream, tready=1 -> tlast on beats 3 and 7, PACKETS=2, done=1, irq=1, tready low from cycle after beat 7.
REQ-032 LENGTH=4, random tvalid/tready gaps (~50% each) -> tlast only on 4th accepted beat; idle cycles never advance BEATS.
REQ-033 LENGTH=8 continuous, write LENGTH=3 after beat 2 -> first packet 8 beats, subsequent packets 3 beats.
REQ-034 LENGTH=5 continuous, clear enable after beat 1 -> beats 2-4 still pass, tlast on beat 4, then IDLE, done=0.
REQ-035 areset mid-packet after beat 2 of LENGTH=6 -> all outputs 0 next cycle, BEATS reads 0; restart yields full 6-beat packet.
REQ-036 Write 0x10 and read 0x1C -> bresp SLVERR, rresp SLVERR, rdata 0, no register change.

Source files
------------

// File: rtl/stream_packetizer.sv
// stream_packetizer: zero-latency AXI-Stream pass-through that frames beats
// into packets of programmable length (tlast), controlled over AXI4-Lite.
module stream_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic                  m_axis_s2mm_tvalid,
    input  logic                  m_axis_s2mm_tready,
    output logic                  m_axis_s2mm_tlast,
    output logic                  last,
    output logic                  irq,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic [2:0]            s_axi_lite_awprot,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [31:0]           s_axi_lite_wdata,
    input  logic [3:0]            s_axi_lite_wstrb,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [1:0]            s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic [2:0]            s_axi_lite_arprot,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [31:0]           s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LENGTH   = 3'd1;
    localparam logic [2:0] REG_NPACKETS = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_BEATS    = 3'd4;
    localparam logic [2:0] REG_PACKETS  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]           ctrl;
    logic [LEN_WIDTH-1:0] length;
    logic [LEN_WIDTH-1:0] npackets;
    logic [LEN_WIDTH-1:0] active_len;
    logic [LEN_WIDTH-1:0] active_npk;
    logic [LEN_WIDTH-1:0] beats;
    logic [LEN_WIDTH-1:0] packets;
    logic [LEN_WIDTH-1:0] packets_inc;
    logic [LEN_WIDTH-1:0] len_m1;
    logic                 done;
    logic                 enable_q;

    logic enable;
    logic continuous;
    logic busy;
    logic streaming;
    logic beat;
    logic final_beat;
    logic shot_last;
    logic done_set;

    logic       wr_hs;
    logic       rd_hs;
    logic [2:0] wr_sel;
    logic [2:0] rd_sel;
    logic       status_clr;

    // Protection bits and undecoded address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                           s_axi_lite_awaddr, s_axi_lite_araddr};

    function automatic logic [31:0] wmerge(input logic [31:0] cur,
                                           input logic [31:0] wd,
                                           input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    assign enable      = ctrl[0];
    assign continuous  = ctrl[1];
    assign busy        = (state != IDLE);
    assign streaming   = ((state == RUN) || (state == DRAIN)) && !areset;
    assign len_m1      = active_len - ONE;
    assign packets_inc = packets + ONE;

    assign beat       = streaming && s_axis_data_tvalid && m_axis_s2mm_tready;
    assign final_beat = beat && (beats == len_m1);
    assign shot_last  = !continuous && (active_npk != '0)
                        && (packets_inc == active_npk);
    assign done_set   = (state == RUN) && final_beat && shot_last;

    // State register
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable && !enable_q && (length != '0)) state_nxt = ARM;
            end
            ARM: state_nxt = RUN;
            RUN: begin
                if (final_beat) begin
                    if (!enable || shot_last || (length == '0))
                        state_nxt = IDLE;
                end else if (!enable) begin
                    state_nxt = ((beats == '0) && !beat) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (final_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stream outputs
    always_comb begin
        s_axis_data_tready = 1'b0;
        m_axis_s2mm_tdata  = '0;
        m_axis_s2mm_tvalid = 1'b0;
        m_axis_s2mm_tlast  = 1'b0;
        last               = 1'b0;
        if (streaming) begin
            s_axis_data_tready = m_axis_s2mm_tready;
            m_axis_s2mm_tdata  = s_axis_data_tdata;
            m_axis_s2mm_tvalid = s_axis_data_tvalid;
            m_axis_s2mm_tlast  = (beats == len_m1);
            last               = final_beat;
        end
    end

    // Packet counters; LENGTH is re-sampled only at packet boundaries.
    always_ff @(posedge aclk) begin
        if (areset) begin
            enable_q   <= 1'b0;
            active_len <= '0;
            active_npk <= '0;
            beats      <= '0;
            packets    <= '0;
        end else begin
            enable_q <= enable;
            if (state == ARM) begin
                active_len <= length;
                active_npk <= npackets;
                beats      <= '0;
                packets    <= '0;
            end else if (final_beat) begin
                beats      <= '0;
                packets    <= packets_inc;
                active_len <= length;
            end else if (beat) begin
                beats <= beats + ONE;
            end
        end
    end

    assign wr_hs  = s_axi_lite_awvalid && s_axi_lite_wvalid
                    && !s_axi_lite_bvalid && !areset;
    assign wr_sel = s_axi_lite_awaddr[4:2];
    assign rd_sel = s_axi_lite_araddr[4:2];
    assign status_clr = wr_hs && (wr_sel == REG_STATUS);

    assign s_axi_lite_awready = wr_hs;
    assign s_axi_lite_wready  = wr_hs;
    assign s_axi_lite_arready = !s_axi_lite_rvalid && !areset;
    assign rd_hs = s_axi_lite_arvalid && s_axi_lite_arready;

    // Write channel and control/status registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl              <= '0;
            length            <= '0;
            npackets          <= '0;
            done              <= 1'b0;
            irq               <= 1'b0;
            s_axi_lite_bvalid <= 1'b0;
            s_axi_lite_bresp  <= RESP_OKAY;
        end else begin
            if (wr_hs) begin
                s_axi_lite_bvalid <= 1'b1;
                s_axi_lite_bresp  <= RESP_OKAY;
                unique case (wr_sel)
                    REG_CTRL: ctrl <= 2'(wmerge({30'b0, ctrl},
                        s_axi_lite_wdata, s_axi_lite_wstrb));
                    REG_LENGTH: length <= LEN_WIDTH'(wmerge(32'(length),
                        s_axi_lite_wdata, s_axi_lite_wstrb));
                    REG_NPACKETS: npackets <= LEN_WIDTH'(wmerge(32'(npackets),
                        s_axi_lite_wdata, s_axi_lite_wstrb));
                    REG_STATUS: ;
                    default: s_axi_lite_bresp <= RESP_SLVERR;
                endcase
            end else if (s_axi_lite_bready) begin
                s_axi_lite_bvalid <= 1'b0;
            end

            // A completion in the same cycle as a clear wins so no event is lost.
            if (done_set) begin
                done <= 1'b1;
                irq  <= 1'b1;
            end else begin
                if ((state == ARM) || status_clr) done <= 1'b0;
                if (status_clr) irq <= 1'b0;
            end
        end
    end

    // Read channel
    always_ff @(posedge aclk) begin
        if (areset) begin
            s_axi_lite_rvalid <= 1'b0;
            s_axi_lite_rdata  <= '0;
            s_axi_lite_rresp  <= RESP_OKAY;
        end else if (rd_hs) begin
            s_axi_lite_rvalid <= 1'b1;
            s_axi_lite_rresp  <= RESP_OKAY;
            unique case (rd_sel)
                REG_CTRL:     s_axi_lite_rdata <= {30'b0, ctrl};
                REG_LENGTH:   s_axi_lite_rdata <= 32'(length);
                REG_NPACKETS: s_axi_lite_rdata <= 32'(npackets);
                REG_STATUS:   s_axi_lite_rdata <= {30'b0, done, busy};
                REG_BEATS:    s_axi_lite_rdata <= 32'(beats);
                REG_PACKETS:  s_axi_lite_rdata <= 32'(packets);
                default: begin
                    s_axi_lite_rdata <= '0;
                    s_axi_lite_rresp <= RESP_SLVERR;
                end
            endcase
        end else if (s_axi_lite_rready) begin
            s_axi_lite_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Randomized scoreboard bench for stream_packetizer: accepted beats are
// checked against a packet-length schedule model; registers against constants.
module tb_stream_packetizer;

    localparam int DW = 32;
    localparam int LW = 32;
    localparam int AW = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_LEN  = 8'h04;
    localparam logic [7:0] A_NPK  = 8'h08;
    localparam logic [7:0] A_STAT = 8'h0C;
    localparam logic [7:0] A_BEAT = 8'h10;
    localparam logic [7:0] A_PKTS = 8'h14;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          last;
    logic          irq;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b1;

    stream_packetizer #(
        .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .m_axis_s2mm_tdata(m_tdata), .m_axis_s2mm_tvalid(m_tvalid),
        .m_axis_s2mm_tready(m_tready), .m_axis_s2mm_tlast(m_tlast),
        .last(last), .irq(irq),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(3'b000),
        .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
        .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
        .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arprot(3'b000),
        .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
        .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          tlast;
    } beat_t;

    beat_t exp_q[$];
    int    sched[$];
    int    pos = 0;
    int    accepted = 0;
    int    rdy_pct = 100;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: word k is the last of its packet when its position
    // reaches the head of the remaining packet-length schedule.
    task automatic push_expected(input logic [DW-1:0] d);
        beat_t e;
        e.data  = d;
        e.tlast = (sched.size() > 0) && (pos + 1 == sched[0]);
        if (e.tlast) begin
            pos = 0;
            void'(sched.pop_front());
        end else begin
            pos++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every downstream handshake pops one expected beat.
    always @(negedge aclk) begin : monitor
        beat_t e;
        if (!areset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: data 0x%08h, none expected",
                         m_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_tdata, e.data);
                check("beat_tlast", 32'(m_tlast), 32'(e.tlast));
                check("beat_last_pulse", 32'(last), 32'(e.tlast));
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge aclk);
            #1;
            m_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_words(input int n, input int vpct);
        logic [DW-1:0] d;
        int guard;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) >= vpct) cycles(1);
            d = $urandom;
            push_expected(d);
            s_tdata  = d;
            s_tvalid = 1'b1;
            guard = 0;
            do begin
                @(negedge aclk);
                guard++;
            end while (!s_tready && guard < 500);
            if (!s_tready) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: word %0d of %0d never accepted",
                         i, n);
                s_tvalid = 1'b0;
                cycles(1);
                return;
            end
            cycles(1);
            s_tvalid = 1'b0;
            accepted++;
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] strb, output logic [1:0] resp);
        int guard;
        awaddr = AW'(a);
        wdata = d;
        wstrb = strb;
        awvalid = 1'b1;
        wvalid = 1'b1;
        guard = 0;
        do begin
            @(negedge aclk);
            guard++;
        end while (!(awready && wready) && guard < 100);
        if (!(awready && wready))
            $display("FAIL aw_timeout: no write handshake at 0x%02h", a);
        cycles(1);
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (!bvalid) $display("FAIL b_timeout: no bvalid at 0x%02h", a);
        resp = bvalid ? bresp : 2'b11;
        cycles(1);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int guard;
        araddr = AW'(a);
        arvalid = 1'b1;
        guard = 0;
        do begin
            @(negedge aclk);
            guard++;
        end while (!arready && guard < 100);
        cycles(1);
        arvalid = 1'b0;
        if (!rvalid) $display("FAIL r_timeout: no rvalid at 0x%02h", a);
        d = rvalid ? rdata : 32'hDEAD_BEEF;
        resp = rvalid ? rresp : 2'b11;
        cycles(1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        check("bresp_okay", 32'(r), 32'(OKAY));
    endtask

    task automatic wr_resp(input string name, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(a, d, strb, r);
        check(name, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a,
                          input logic [31:0] exp, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0] r;
        axi_read(a, d, r);
        check(name, d, exp);
        check({name, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({s_tready, m_tvalid, m_tlast, last, irq, awready,
                         wready, arready, bvalid, rvalid}), 32'(0));
        check({name, "_tdata"}, m_tdata, '0);
    endtask

    task automatic start_run(input int len, input int npk,
                             input logic [31:0] ctrl);
        wr(A_CTRL, 32'h0);
        wr(A_LEN, 32'(len));
        wr(A_NPK, 32'(npk));
        accepted = 0;
        pos = 0;
        wr(A_CTRL, ctrl);
    endtask

    initial begin : stimulus
        // Reset state
        cycles(2);
        @(negedge aclk);
        check_reset_outputs("reset_outputs");
        @(posedge aclk);
        #1;
        areset = 1'b0;
        cycles(1);
        rd_chk("rst_ctrl", A_CTRL, 32'h0, OKAY);
        rd_chk("rst_length", A_LEN, 32'h0, OKAY);
        rd_chk("rst_npackets", A_NPK, 32'h0, OKAY);
        rd_chk("rst_status", A_STAT, 32'h0, OKAY);
        rd_chk("rst_beats", A_BEAT, 32'h0, OKAY);
        rd_chk("rst_packets", A_PKTS, 32'h0, OKAY);

        // Register file: byte strobes, ro/unmapped errors, unused bits
        wr(A_LEN, 32'h1122_3344);
        wr_resp("strb_write", A_LEN, 32'hAABB_CCDD, 4'b0101, OKAY);
        rd_chk("strb_length", A_LEN, 32'h11BB_33DD, OKAY);
        wr_resp("ro_beats_wr", A_BEAT, 32'hFFFF_FFFF, 4'hF, SLVERR);
        wr_resp("ro_packets_wr", A_PKTS, 32'h5, 4'hF, SLVERR);
        wr_resp("unmapped_wr", 8'h18, 32'h7, 4'hF, SLVERR);
        rd_chk("unmapped_rd", 8'h1C, 32'h0, SLVERR);
        rd_chk("beats_after_wr", A_BEAT, 32'h0, OKAY);
        rd_chk("length_kept", A_LEN, 32'h11BB_33DD, OKAY);
        wr(A_CTRL, 32'hFFFF_FFFE);
        rd_chk("ctrl_width", A_CTRL, 32'h2, OKAY);

        // Enable with LENGTH=0 never starts
        wr(A_CTRL, 32'h0);
        wr(A_LEN, 32'h0);
        wr(A_CTRL, 32'h1);
        cycles(3);
        rd_chk("len0_idle", A_STAT, 32'h0, OKAY);

        // One-shot 2 x 4 beats, no gaps
        rdy_pct = 100;
        sched = '{4, 4};
        start_run(4, 2, 32'h1);
        send_words(8, 100);
        @(negedge aclk);
        check("tready_low_after_done", 32'(s_tready), 32'(0));
        check("irq_after_done", 32'(irq), 32'(1));
        cycles(1);
        rd_chk("oneshot_status", A_STAT, 32'h2, OKAY);
        rd_chk("oneshot_packets", A_PKTS, 32'h2, OKAY);
        rd_chk("oneshot_beats", A_BEAT, 32'h0, OKAY);
        wr(A_STAT, 32'h0);
        @(negedge aclk);
        check("irq_cleared", 32'(irq), 32'(0));
        cycles(1);
        rd_chk("status_cleared", A_STAT, 32'h0, OKAY);
        check("sb_drain_oneshot", 32'(exp_q.size()), 32'(0));

        // One-shot 3 x 4 beats with random gaps on both sides
        rdy_pct = 50;
        sched = '{4, 4, 4};
        start_run(4, 3, 32'h1);
        send_words(12, 50);
        cycles(2);
        rd_chk("gaps_status", A_STAT, 32'h2, OKAY);
        rd_chk("gaps_packets", A_PKTS, 32'h3, OKAY);
        wr(A_STAT, 32'h0);
        check("sb_drain_gaps", 32'(exp_q.size()), 32'(0));

        // Single-beat packets: every beat is last
        rdy_pct = 70;
        sched = '{1, 1, 1};
        start_run(1, 3, 32'h1);
        send_words(3, 60);
        cycles(2);
        rd_chk("len1_packets", A_PKTS, 32'h3, OKAY);
        rd_chk("len1_status", A_STAT, 32'h2, OKAY);
        wr(A_STAT, 32'h0);

        // Continuous; LENGTH rewritten mid-packet applies at the boundary
        rdy_pct = 100;
        sched = '{8, 3, 3};
        start_run(8, 0, 32'h3);
        fork
            send_words(14, 80);
            begin
                wait (accepted >= 3);
                wr(A_LEN, 32'h3);
            end
        join
        wr(A_CTRL, 32'h2);
        cycles(2);
        rd_chk("relatch_status", A_STAT, 32'h0, OKAY);
        rd_chk("relatch_packets", A_PKTS, 32'h3, OKAY);
        check("sb_drain_relatch", 32'(exp_q.size()), 32'(0));

        // Continuous; enable cleared mid-packet drains it without done
        rdy_pct = 50;
        sched = '{5};
        start_run(5, 0, 32'h3);
        fork
            send_words(5, 60);
            begin
                wait (accepted >= 2);
                wr(A_CTRL, 32'h2);
            end
        join
        cycles(3);
        rd_chk("drain_status", A_STAT, 32'h0, OKAY);
        rd_chk("drain_packets", A_PKTS, 32'h1, OKAY);
        check("drain_irq", 32'(irq), 32'(0));
        check("sb_drain_drain", 32'(exp_q.size()), 32'(0));

        // Reset mid-packet, then a full restart
        rdy_pct = 100;
        sched = '{6};
        start_run(6, 1, 32'h1);
        send_words(3, 100);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("midreset_outputs");
        cycles(1);
        areset = 1'b0;
        sched.delete();
        pos = 0;
        check("sb_after_reset", 32'(exp_q.size()), 32'(0));
        rd_chk("midreset_beats", A_BEAT, 32'h0, OKAY);
        rd_chk("midreset_length", A_LEN, 32'h0, OKAY);
        rd_chk("midreset_status", A_STAT, 32'h0, OKAY);
        sched = '{6};
        start_run(6, 1, 32'h1);
        send_words(6, 100);
        cycles(1);
        rd_chk("restart_status", A_STAT, 32'h2, OKAY);
        rd_chk("restart_packets", A_PKTS, 32'h1, OKAY);
        check("sb_drain_final", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
